contador_scan_ctrl: RTL and testbench

Readout sequencer for the FIFO occupancy counter block (five 5-bit counters read through `req`/`idx`, answered with `data`/`valid`). On a single `start` pulse it walks `idx` from 0 to NUM_CNT-1, holds `req` for each index until the counter answers, and forwards each count as a one-cycle result beat. It also accumulates the total occupancy and flags completion. It sits between the counter block and the flow-control/reporting logic, and is the only master of the counter's `req`/`idx` inputs.

---
 rtl/contador_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_contador_scan_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_scan_ctrl.sv
// Readout sequencer for the FIFO occupancy counters: walks idx, forwards each count, sums the total.
// Optional per-index wait timeout with error mask is built when SCAN_TIMEOUT_EN is defined.
module contador_scan_ctrl #(
    parameter int NUM_CNT = 5,
    parameter int TIMEOUT = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_L,
    input  logic       i_start,
    input  logic [4:0] i_data_in,
    input  logic       i_valid_in,
    output logic       o_req,
    output logic [2:0] o_idx,
    output logic [4:0] o_out_data,
    output logic [2:0] o_out_idx,
    output logic       o_out_valid,
    output logic [7:0] o_total,
    output logic       o_busy,
    output logic       o_done,
    output logic [4:0] o_err_mask
);

    // state | meaning
    // IDLE  | waiting for start, idx holds last value
    // WAIT  | req high, waiting for the counter to answer
    // GAP   | one cycle with req low before the next index
    // DONE  | last beat out; done strobes on the way back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_DONE} state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_CNT - 1);

    if (NUM_CNT < 1 || NUM_CNT > 5) begin : g_bad_num_cnt
        $error("contador_scan_ctrl: NUM_CNT must be 1..5");
    end
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("contador_scan_ctrl: TIMEOUT must be 1..15");
    end

    state_t     r_state,       w_state_nx;
    logic       r_req,         w_req_nx;
    logic [2:0] r_idx,         w_idx_nx;
    logic [4:0] r_out_data,    w_out_data_nx;
    logic [2:0] r_out_idx,     w_out_idx_nx;
    logic       r_out_valid,   w_out_valid_nx;
    logic [7:0] r_total,       w_total_nx;
    logic       r_busy,        w_busy_nx;
    logic       r_done,        w_done_nx;
    logic       w_advance;
`ifdef SCAN_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
    logic [4:0] r_err_mask,    w_err_nx;
    logic [3:0] r_wait_cnt,    w_wait_cnt_nx;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_req_nx       = r_req;
        w_idx_nx       = r_idx;
        w_out_data_nx  = r_out_data;
        w_out_idx_nx   = r_out_idx;
        w_out_valid_nx = 1'b0;
        w_total_nx     = r_total;
        w_busy_nx      = r_busy;
        w_done_nx      = 1'b0;
        w_advance      = 1'b0;
`ifdef SCAN_TIMEOUT_EN
        w_err_nx       = r_err_mask;
        w_wait_cnt_nx  = r_wait_cnt;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nx = S_WAIT;
                    w_req_nx   = 1'b1;
                    w_idx_nx   = 3'd0;
                    w_busy_nx  = 1'b1;
                    w_total_nx = 8'd0;
`ifdef SCAN_TIMEOUT_EN
                    w_err_nx      = 5'd0;
                    w_wait_cnt_nx = 4'd0;
`endif
                end
            end
            S_WAIT: begin
                if (i_valid_in) begin
                    w_advance     = 1'b1;
                    w_out_data_nx = i_data_in;
                    w_total_nx    = r_total + {3'b000, i_data_in};
                end
`ifdef SCAN_TIMEOUT_EN
                // A late valid_in in the timeout cycle still wins, so timeout is checked second.
                else if (r_wait_cnt == TO_LAST) begin
                    w_advance     = 1'b1;
                    w_out_data_nx = 5'd0;
                    w_err_nx      = r_err_mask | (5'd1 << r_idx);
                end else begin
                    w_wait_cnt_nx = r_wait_cnt + 4'd1;
                end
`endif
                if (w_advance) begin
                    w_out_idx_nx   = r_idx;
                    w_out_valid_nx = 1'b1;
                    w_req_nx       = 1'b0;
                    w_state_nx     = (r_idx < LAST_IDX) ? S_GAP : S_DONE;
                end
            end
            S_GAP: begin
                w_idx_nx   = r_idx + 3'd1;
                w_req_nx   = 1'b1;
                w_state_nx = S_WAIT;
`ifdef SCAN_TIMEOUT_EN
                w_wait_cnt_nx = 4'd0;
`endif
            end
            S_DONE: begin
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_L) begin
        if (!i_reset_L) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_idx       <= 3'd0;
            r_out_data  <= 5'd0;
            r_out_idx   <= 3'd0;
            r_out_valid <= 1'b0;
            r_total     <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_req       <= w_req_nx;
            r_idx       <= w_idx_nx;
            r_out_data  <= w_out_data_nx;
            r_out_idx   <= w_out_idx_nx;
            r_out_valid <= w_out_valid_nx;
            r_total     <= w_total_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_reset_L) begin
        if (!i_reset_L) begin
            r_err_mask <= 5'd0;
            r_wait_cnt <= 4'd0;
        end else begin
            r_err_mask <= w_err_nx;
            r_wait_cnt <= w_wait_cnt_nx;
        end
    end
    assign o_err_mask = r_err_mask;
`else
    assign o_err_mask = 5'd0;
`endif

    assign o_req       = r_req;
    assign o_idx       = r_idx;
    assign o_out_data  = r_out_data;
    assign o_out_idx   = r_out_idx;
    assign o_out_valid = r_out_valid;
    assign o_total     = r_total;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_contador_scan_ctrl.sv
// Directed bench for contador_scan_ctrl: a counter-block responder pushes expected beats to a
// scoreboard, which is popped on out_valid. Timeout scan runs only when SCAN_TIMEOUT_EN is defined.
module tb_contador_scan_ctrl;
    localparam int NUM  = 5;
    localparam int TO_P = 8;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       start;
    logic [4:0] data_in;
    logic       valid_in;
    logic       o_req;
    logic [2:0] o_idx;
    logic [4:0] o_out_data;
    logic [2:0] o_out_idx;
    logic       o_out_valid;
    logic [7:0] o_total;
    logic       o_busy;
    logic       o_done;
    logic [4:0] o_err_mask;

    contador_scan_ctrl #(.NUM_CNT(NUM), .TIMEOUT(TO_P)) dut (
        .i_clk(clk), .i_reset_L(reset_L), .i_start(start), .i_data_in(data_in),
        .i_valid_in(valid_in), .o_req(o_req), .o_idx(o_idx), .o_out_data(o_out_data),
        .o_out_idx(o_out_idx), .o_out_valid(o_out_valid), .o_total(o_total),
        .o_busy(o_busy), .o_done(o_done), .o_err_mask(o_err_mask)
    );

    always #5 clk = ~clk;

    wire [27:0] all_outs = {o_req, o_idx, o_out_data, o_out_idx, o_out_valid,
                            o_total, o_busy, o_done, o_err_mask};

    typedef struct packed {
        logic [2:0] idx;
        logic [4:0] data;
    } beat_t;
    beat_t sbq[$];

    int total_n = 0;
    int bad_n   = 0;
    int cyc     = 0;
    logic [4:0] cnts[8];
    int  dly[8];
    bit  silent[8];
    int  req_len[8];
    int  cur_k = 0, run = 0, low_run = 0, busy_n = 0, done_n = 0, done_base = 0;
    int  last_ov_cyc = 0, exp_total = 0;
    bit  prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_true(input string tag, input bit cond);
        total_n++;
        assert (cond) else begin
            bad_n++;
            $error("FAIL %s: observed=0 expected=1", tag);
        end
    endtask

    function automatic int sum_model();
        int s = 0;
        for (int i = 0; i < NUM; i++) if (!silent[i]) s += int'(cnts[i]);
        return s;
    endfunction

    function automatic logic [4:0] err_model();
        logic [4:0] m = 5'd0;
`ifdef SCAN_TIMEOUT_EN
        for (int i = 0; i < NUM; i++) m[i] = silent[i];
`endif
        return m;
    endfunction

    // Counter-block responder plus output monitor, both sampled on the falling edge.
    initial begin
        beat_t b;
        valid_in = 1'b0;
        data_in  = 5'd0;
        forever begin
            @(negedge clk);
            if (!reset_L) begin
                valid_in = 1'b0;
                prev_req = 1'b0;
                run      = 0;
                low_run  = 0;
            end else begin
                if (o_out_valid) begin
                    chk_true("beat_expected", sbq.size() != 0);
                    if (sbq.size() != 0) begin
                        b = sbq.pop_front();
                        chk("out_idx", o_out_idx, b.idx);
                        chk("out_data", o_out_data, b.data);
                        exp_total += int'(b.data);
                        chk("total_with_beat", o_total, exp_total);
                        last_ov_cyc = cyc;
                    end
                end
                if (o_done) begin
                    done_n++;
                    chk("done_after_last_beat", cyc - last_ov_cyc, 1);
                end
                if (o_busy) busy_n++;
                if (o_busy && !o_req) low_run++;
                if (!o_busy) low_run = 0;
                if (o_req) begin
                    if (!prev_req) begin
                        chk("idx_at_req", o_idx, cur_k);
                        if (low_run != 0) chk("gap_len", low_run, 1);
                        low_run = 0;
                        run     = 0;
                    end else begin
                        chk("idx_stable", o_idx, cur_k);
                    end
                    run++;
                    if (cur_k < 8 && !silent[cur_k] && run > dly[cur_k]) begin
                        valid_in = 1'b1;
                        data_in  = cnts[cur_k];
                        sbq.push_back('{idx: 3'(cur_k), data: cnts[cur_k]});
                    end else begin
                        valid_in = 1'b0;
                        data_in  = 5'($urandom);
                        if (cur_k < 8 && silent[cur_k] && run == TO_P)
                            sbq.push_back('{idx: 3'(cur_k), data: 5'd0});
                    end
                end else begin
                    if (prev_req) begin
                        if (cur_k < 8) req_len[cur_k] = run;
                        cur_k++;
                    end
                    valid_in = 1'b0;
                    data_in  = 5'($urandom);
                end
                prev_req = o_req;
            end
        end
    end

    task automatic start_scan(input bit pre_started);
        if (!pre_started) begin
            @(negedge clk); #1;
            exp_total = 0; cur_k = 0; busy_n = 0; done_base = done_n;
            start = 1'b1;
        end
        @(negedge clk); #1;
        start = 1'b0;
        chk("start_req_idx_busy", {o_req, o_idx, o_busy}, {1'b1, 3'd0, 1'b1});
        chk("start_total_clr", o_total, 0);
    endtask

    task automatic finish_scan(input string tag, input int busy_exp, input bit chain);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk_true({tag, "_done_seen"}, seen);
        chk({tag, "_busy_cycles"}, busy_n, busy_exp);
        chk({tag, "_beats_left"}, sbq.size(), 0);
        chk({tag, "_done_count"}, done_n - done_base, 1);
        chk({tag, "_indices"}, cur_k, NUM);
        chk({tag, "_total"}, o_total, sum_model());
        chk({tag, "_err_mask"}, o_err_mask, err_model());
        chk({tag, "_busy_low"}, o_busy, 0);
        if (chain) begin
            exp_total = 0; cur_k = 0; busy_n = 0; done_base = done_n;
            start = 1'b1;
        end
    endtask

    task automatic set_scan(input logic [4:0] c0, c1, c2, c3, c4);
        cnts[0] = c0; cnts[1] = c1; cnts[2] = c2; cnts[3] = c3; cnts[4] = c4;
        for (int i = 0; i < 8; i++) begin
            dly[i] = 0;
            silent[i] = 1'b0;
            req_len[i] = 0;
        end
    endtask

    task automatic wait_idx(input string tag, input int k);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (cur_k == k && o_req) begin
                found = 1'b1;
                break;
            end
        end
        chk_true(tag, found);
    endtask

    initial begin
        int d;
        reset_L = 1'b0;
        start   = 1'b0;
        set_scan(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 5; i < 8; i++) cnts[i] = 5'd0;

        // Reset then idle
        repeat (3) @(negedge clk);
        #1 chk("reset_outputs", all_outs, 0);
        reset_L = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("idle_outputs", all_outs, 0);
        end

        // Immediate answers
        set_scan(5'd3, 5'd0, 5'd7, 5'd31, 5'd1);
        start_scan(1'b0);
        finish_scan("imm", 10, 1'b0);
        chk("imm_total_42", o_total, 42);

        // idx 2 answered 3 cycles late
        set_scan(5'd5, 5'd9, 5'd12, 5'd2, 5'd20);
        dly[2] = 3;
        start_scan(1'b0);
        finish_scan("dly", 13, 1'b0);
        chk("dly_req_hold_idx2", req_len[2], 4);
        chk("dly_req_hold_idx0", req_len[0], 1);

        // start pulsed during idx 1 WAIT, then back-to-back scan
        set_scan(5'd1, 5'd2, 5'd3, 5'd4, 5'd5);
        dly[1] = 2;
        start_scan(1'b0);
        wait_idx("reach_idx1", 1);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        finish_scan("busy_start", 12, 1'b1);
        set_scan(5'd10, 5'd11, 5'd0, 5'd6, 5'd31);
        start_scan(1'b1);
        finish_scan("b2b", 10, 1'b0);

        // Reset during idx 3 WAIT
        set_scan(5'd4, 5'd4, 5'd4, 5'd4, 5'd4);
        dly[3] = 100;
        start_scan(1'b0);
        wait_idx("reach_idx3", 3);
        repeat (2) @(negedge clk);
        #2 reset_L = 1'b0;
        #1 chk("midreset_outputs", all_outs, 0);
        chk("midreset_beats_left", sbq.size(), 0);
        sbq.delete();
        d = done_n;
        repeat (2) @(negedge clk);
        #1 reset_L = 1'b1;
        repeat (4) @(negedge clk);
        #1 chk("midreset_no_done", done_n, d);
        chk("midreset_idle_outputs", all_outs, 0);

        set_scan(5'd31, 5'd31, 5'd31, 5'd31, 5'd31);
        start_scan(1'b0);
        finish_scan("post_reset", 10, 1'b0);
        chk("post_reset_total_155", o_total, 155);

`ifdef SCAN_TIMEOUT_EN
        set_scan(5'd2, 5'd9, 5'd3, 5'd4, 5'd5);
        silent[1] = 1'b1;
        start_scan(1'b0);
        finish_scan("timeout", 17, 1'b0);
        chk("timeout_req_hold_idx1", req_len[1], TO_P);
        chk("timeout_err_mask", o_err_mask, 5'b00010);
        silent[1] = 1'b0;
`endif

        d = done_n;
        repeat (5) @(negedge clk);
        #1 chk("final_no_done", done_n, d);
        chk("final_idle", {o_req, o_busy, o_out_valid}, 3'b000);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
